kw_pipe_reg_elastic: RTL and testbench
======================================

// Module: kw_pipe_reg_elastic
// PURPOSE
//   Multi-stage pipeline register with a valid/ready handshake, backpressure, flush and occupancy count.
//   Next generation of the valid-only pipeline register: data may stall in the pipe without loss.
//   Sits between datapath units whose consumer can stall, e.g. a multiplier feeding a FIFO.
//   Optional registered-ready (skid) mode breaks the combinational ready path for timing closure.
// PARAMETERS
//   DATA_WIDTH  (none)  payload width in bits, >= 1
//   DEPTH       1       number of register stages, >= 1; elaboration error if 0
//   REG_READY   0       0: ready chained combinationally, capacity DEPTH entries
//                       1: each stage has a main and a skid entry, ready is registered, capacity 2*DEPTH
//   CW          $clog2(2*DEPTH+1)  width of count (localparam, not overridable)
// PORTS
//   clock    in   1           single clock, rising edge
//   reset    in   1           asynchronous, active-high
//   flush    in   1           synchronous clear of all entries
//   i_v      in   1           input valid
//   i_r      out  1           input ready
//   i        in   DATA_WIDTH  input payload
//   o_v      out  1           output valid
//   o_r      in   1           output ready
//   o        out  DATA_WIDTH  output payload
//   count    out  CW          number of valid entries held
// BEHAVIOUR
//   Interface: one clock; reset is asynchronous and active-high.
//   - Reset (async, immediate, no clock needed): every stage valid and skid valid = 0.
//     Outputs: o_v=0, count=0, i_r=1. Data registers are not reset; o is undefined while o_v=0.
//   - Transfer: input on i_v&i_r at a rising edge; output on o_v&o_r at a rising edge.
//   - Once o_v=1, o_v stays 1 and o stays stable until o_r=1 (flush and reset excepted).
//   - Ordering: strict FIFO; no drop, no duplicate.
//   - Latency: an input accepted at edge N is presented with o_v=1 after edge N+DEPTH-1,
//     i.e. visible DEPTH cycles after the input cycle, when nothing ahead stalls.
//   - Throughput: 1 transfer per cycle when o_r=1 continuously.
//   - REG_READY=0:
//     - Stage k advances when ~v[k] | ready[k+1], with ready[DEPTH]=o_r.
//     - i_r = ~v[0] | ready[1], so a combinational path o_r -> i_r exists.
//     - Bubbles collapse: an empty stage always accepts.
//   - REG_READY=1:
//     - Per stage: main entry plus skid entry. ready out of stage k = ~skid_v[k], taken from a flop.
//     - When downstream stalls, the incoming word lands in skid.
//     - Skid drains into main before new input is taken.
//     - No combinational path from o_r to i_r or to any output.
//   - Full:
//     - i_r=0 when count == capacity and no output transfer is possible.
//     - In REG_READY=0, i_r=1 at full while o_r=1.
//   - Empty: o_v=0 when count=0. There is no bypass, so an input is never visible in the same cycle.
//   - count:
//     - next = count + (i_v&i_r) - (o_v&o_r).
//     - Never exceeds capacity and never wraps.
//   - flush (priority over all transfers):
//     - After the edge: all valids = 0 and count = 0.
//     - An input accepted in the flush cycle is discarded.
//     - An output handshake in the flush cycle still completes.
//     - i_r is unaffected by flush.
//   - reset mid-stream: all in-flight data is lost. After deassertion the block behaves as after power-up.
// TESTING
//   1. DEPTH=3, REG_READY=0, o_r=1, push 0..9 back-to-back
//      -> o=0 with o_v=1 three cycles after first accept; 0..9 on consecutive cycles; count holds 3.
//   2. o_r=0, push until i_r=0
//      -> DEPTH=3 accepts 3 (REG_READY=0) or 6 (REG_READY=1); count=3/6.
//      Then raise o_r -> data drains in order and count reaches 0.
//   3. Random i_v/o_r (50%), 10k cycles, both modes, DEPTH in {1,2,4}
//      -> scoreboard matches in order; o stable while o_v&~o_r; count equals the model every cycle.
//   4. count=4 and i_v=1, pulse flush one cycle
//      -> next cycle o_v=0, count=0; flushed words and the concurrent input never appear at o.
//   5. Assert reset between clock edges mid-stream
//      -> o_v=0, count=0, i_r=1 immediately. After release, push 0xA5 -> emerges after DEPTH cycles.
//   6. REG_READY=1, clock held, toggle o_r
//      -> i_r, o_v, o, count unchanged (no combinational path).

Source files
------------

// File: rtl/kw_pipe_reg_elastic.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : kw_pipe_reg_elastic                                        |
// | Description : Multi-stage elastic pipeline register with valid/ready     |
// |               handshake, backpressure, synchronous flush and occupancy   |
// |               count. REG_READY=1 adds a skid entry per stage so that     |
// |               ready is taken from flops only.                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module kw_pipe_reg_elastic #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 1,
  parameter int REG_READY  = 0,
  localparam int CW        = $clog2(2*DEPTH+1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  i_v,
  output logic                  i_r,
  input  logic [DATA_WIDTH-1:0] i,
  output logic                  o_v,
  input  logic                  o_r,
  output logic [DATA_WIDTH-1:0] o,
  output logic [CW-1:0]         count
);

  generate
    if (DEPTH < 1) begin : g_bad_depth
      $error("kw_pipe_reg_elastic: DEPTH must be >= 1");
    end
  endgenerate

  logic          w_in_fire;
  logic          w_out_fire;
  logic [CW-1:0] r_count;

  assign w_in_fire  = i_v & i_r;
  assign w_out_fire = o_v & o_r;
  assign count      = r_count;

  // Occupancy: +1 per accepted input, -1 per delivered output, cleared by flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + {{(CW-1){1'b0}}, w_in_fire} - {{(CW-1){1'b0}}, w_out_fire};
    end
  end

  generate
    if (REG_READY == 0) begin : g_comb_ready
      // Single entry per stage; ready ripples back combinationally from o_r.
      logic [DEPTH-1:0]      r_v;
      logic [DATA_WIDTH-1:0] r_d     [DEPTH];
      logic [DEPTH:0]        w_rdy;
      logic [DEPTH-1:0]      w_src_v;
      logic [DATA_WIDTH-1:0] w_src_d [DEPTH];

      // A stage can load when it is empty or the stage after it is loading.
      always_comb begin
        w_rdy        = '0;
        w_rdy[DEPTH] = o_r;
        for (int k = DEPTH-1; k >= 0; k--) begin
          w_rdy[k] = ~r_v[k] | w_rdy[k+1];
        end
      end

      // Each stage is fed by the stage before it; stage 0 by the input port.
      always_comb begin
        w_src_v[0] = i_v;
        w_src_d[0] = i;
        for (int k = 1; k < DEPTH; k++) begin
          w_src_v[k] = r_v[k-1];
          w_src_d[k] = r_d[k-1];
        end
      end

      // Valid bits shift forward wherever the stage is ready; bubbles collapse.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_v <= '0;
        end else if (flush) begin
          r_v <= '0;
        end else begin
          for (int k = 0; k < DEPTH; k++) begin
            if (w_rdy[k]) r_v[k] <= w_src_v[k];
          end
        end
      end

      // Payload is captured only when a valid word actually moves in.
      always_ff @(posedge clock) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (w_rdy[k] & w_src_v[k]) r_d[k] <= w_src_d[k];
        end
      end

      assign i_r = w_rdy[0];
      assign o_v = r_v[DEPTH-1];
      assign o   = r_d[DEPTH-1];
    end else begin : g_skid_ready
      // Main plus skid entry per stage; upstream ready is ~skid valid (a flop).
      logic [DEPTH-1:0]      r_mv;
      logic [DEPTH-1:0]      r_sv;
      logic [DATA_WIDTH-1:0] r_md    [DEPTH];
      logic [DATA_WIDTH-1:0] r_sd    [DEPTH];
      logic [DEPTH-1:0]      w_up_v;
      logic [DATA_WIDTH-1:0] w_up_d  [DEPTH];
      logic [DEPTH-1:0]      w_dn_r;
      logic [DEPTH-1:0]      w_in_f;
      logic [DEPTH-1:0]      w_out_f;

      // Per-stage handshakes; downstream ready is the next stage's registered ~skid.
      always_comb begin
        w_up_v[0] = i_v;
        w_up_d[0] = i;
        for (int k = 1; k < DEPTH; k++) begin
          w_up_v[k] = r_mv[k-1];
          w_up_d[k] = r_md[k-1];
        end
        w_dn_r[DEPTH-1] = o_r;
        for (int k = 0; k < DEPTH-1; k++) begin
          w_dn_r[k] = ~r_sv[k+1];
        end
        w_in_f  = w_up_v & ~r_sv;
        w_out_f = r_mv & w_dn_r;
      end

      // Skid fills only when main is held; a full skid refills main before new input.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_mv <= '0;
          r_sv <= '0;
        end else if (flush) begin
          r_mv <= '0;
          r_sv <= '0;
        end else begin
          for (int k = 0; k < DEPTH; k++) begin
            if (r_sv[k]) begin
              if (w_out_f[k]) r_sv[k] <= 1'b0;
            end else if (w_in_f[k]) begin
              if (r_mv[k] & ~w_out_f[k]) r_sv[k] <= 1'b1;
              else                       r_mv[k] <= 1'b1;
            end else if (w_out_f[k]) begin
              r_mv[k] <= 1'b0;
            end
          end
        end
      end

      // Payload moves: skid->main on drain, input->main or input->skid on accept.
      always_ff @(posedge clock) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (r_sv[k]) begin
            if (w_out_f[k]) r_md[k] <= r_sd[k];
          end else if (w_in_f[k]) begin
            if (r_mv[k] & ~w_out_f[k]) r_sd[k] <= w_up_d[k];
            else                       r_md[k] <= w_up_d[k];
          end
        end
      end

      assign i_r = ~r_sv[0];
      assign o_v = r_mv[DEPTH-1];
      assign o   = r_md[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_kw_pipe_reg_elastic.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_kw_pipe_reg_elastic                                     |
// | Description : Self-checking bench for kw_pipe_reg_elastic. Eight DUTs    |
// |               (DEPTH 1..4, both ready modes) share one stimulus stream;  |
// |               each is checked against a queue-based reference model.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_kw_pipe_reg_elastic;

  localparam int NI = 8;

  function automatic int dep_of(input int g);
    case (g)
      0, 1:    return 3;
      2, 3:    return 1;
      4, 5:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int rr_of(input int g);
    return g % 2;
  endfunction

  function automatic int cap_of(input int g);
    return (rr_of(g) == 1) ? 2*dep_of(g) : dep_of(g);
  endfunction

  logic       clock = 1'b0;
  logic       clk_run = 1'b1;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic       i_v = 1'b0;
  logic       o_r = 1'b0;
  logic [7:0] din = 8'h00;

  logic       ir  [NI];
  logic       ov  [NI];
  logic [7:0] od  [NI];
  logic [7:0] cnt [NI];

  always begin
    #5;
    if (clk_run) clock = ~clock;
  end

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int GD = dep_of(g);
    localparam int GR = rr_of(g);
    localparam int GC = $clog2(2*GD+1);
    logic [GC-1:0] w_cnt;
    kw_pipe_reg_elastic #(.DATA_WIDTH(8), .DEPTH(GD), .REG_READY(GR)) u_dut (
      .clock(clock), .reset(reset), .flush(flush),
      .i_v(i_v), .i_r(ir[g]), .i(din),
      .o_v(ov[g]), .o_r(o_r), .o(od[g]), .count(w_cnt)
    );
    assign cnt[g] = {{(8-GC){1'b0}}, w_cnt};
  end

  // Reference model: ordered contents plus the edge index each word was accepted on.
  typedef struct packed {
    logic [7:0]  d;
    logic [31:0] a;
  } ent_t;
  ent_t q [NI][$];

  int         total = 0;
  int         bad   = 0;
  int         edge_n = 0;
  logic       s_ir [NI];
  logic       s_ov [NI];
  logic [7:0] s_od [NI];
  logic       hold [NI];
  logic [7:0] held [NI];

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       orr;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_o;
    int         e_cnt;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input bit ok, input string nm, input int g, input int act, input int exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s inst%0d (depth=%0d rr=%0d) t=%0t actual=%0h required=%0h",
               nm, g, dep_of(g), rr_of(g), $time, act, exp);
    end
  endtask

  // Compare every DUT against its model just before the coming edge.
  task automatic settle_check();
    #3;
    for (int g = 0; g < NI; g++) begin
      automatic int sz = q[g].size();
      s_ir[g] = ir[g];
      s_ov[g] = ov[g];
      s_od[g] = od[g];
      chk(cnt[g] == 8'(sz), "count", g, cnt[g], sz);
      if (ov[g]) begin
        chk(sz > 0, "ov_when_empty", g, 1, 0);
        if (sz > 0) begin
          chk(od[g] == q[g][0].d, "o_order", g, od[g], q[g][0].d);
          chk((edge_n - int'(q[g][0].a)) >= dep_of(g), "too_early", g,
              edge_n - int'(q[g][0].a), dep_of(g));
        end
      end
      if (rr_of(g) == 0) begin
        chk(ir[g] == ((sz < dep_of(g)) || o_r), "i_r_chain", g, ir[g],
            int'((sz < dep_of(g)) || o_r));
      end else begin
        if (sz == cap_of(g)) chk(ir[g] == 1'b0, "i_r_full", g, ir[g], 0);
        if (sz == 0)         chk(ir[g] == 1'b1, "i_r_empty", g, ir[g], 1);
      end
      if (hold[g]) begin
        chk(ov[g] == 1'b1, "ov_drop", g, ov[g], 1);
        chk(od[g] == held[g], "o_stable", g, od[g], held[g]);
      end
    end
  endtask

  // Apply the handshakes seen before the edge to the model.
  task automatic advance();
    @(posedge clock);
    for (int g = 0; g < NI; g++) begin
      if (flush) begin
        q[g].delete();
      end else begin
        if (s_ov[g] && o_r && q[g].size() > 0) void'(q[g].pop_front());
        if (i_v && s_ir[g]) q[g].push_back({din, 32'(edge_n)});
      end
      hold[g] = s_ov[g] && !o_r && !flush;
      held[g] = s_od[g];
    end
    edge_n++;
    #1;
  endtask

  task automatic tick();
    settle_check();
    advance();
  endtask

  task automatic model_reset();
    for (int g = 0; g < NI; g++) begin
      q[g].delete();
      hold[g] = 1'b0;
    end
  endtask

  task automatic check_reset_state(input string nm);
    for (int g = 0; g < NI; g++) begin
      chk(ov[g] == 1'b0, {nm, "_ov"}, g, ov[g], 0);
      chk(cnt[g] == 8'd0, {nm, "_cnt"}, g, cnt[g], 0);
      chk(ir[g] == 1'b1, {nm, "_ir"}, g, ir[g], 1);
    end
  endtask

  initial begin
    logic       snap_ir [NI];
    logic       snap_ov [NI];
    logic [7:0] snap_od [NI];
    logic [7:0] snap_cn [NI];

    model_reset();
    for (int t = 0; t < 14; t++) begin
      tbl[t].iv    = (t < 10);
      tbl[t].d     = (t < 10) ? 8'(t) : 8'h00;
      tbl[t].orr   = 1'b1;
      tbl[t].e_ir  = 1'b1;
      tbl[t].e_ov  = (t >= 3) && (t <= 12);
      tbl[t].e_o   = 8'(t - 3);
      tbl[t].e_cnt = ((t < 10) ? t : 10) - ((t > 3) ? (((t - 3) < 10) ? (t - 3) : 10) : 0);
    end

    // Power-up reset.
    repeat (2) @(posedge clock);
    #1;
    check_reset_state("reset_pwrup");
    reset = 1'b0;

    // Back-to-back stream through DEPTH=3 with o_r held high.
    for (int t = 0; t < 14; t++) begin
      i_v = tbl[t].iv;
      din = tbl[t].d;
      o_r = tbl[t].orr;
      settle_check();
      for (int g = 0; g < 2; g++) begin
        chk(ir[g] == tbl[t].e_ir, "tbl_ir", g, ir[g], tbl[t].e_ir);
        chk(ov[g] == tbl[t].e_ov, "tbl_ov", g, ov[g], tbl[t].e_ov);
        chk(cnt[g] == 8'(tbl[t].e_cnt), "tbl_cnt", g, cnt[g], tbl[t].e_cnt);
        if (tbl[t].e_ov) chk(od[g] == tbl[t].e_o, "tbl_o", g, od[g], tbl[t].e_o);
      end
      advance();
    end

    // Fill with o_r low until every pipe refuses input.
    o_r = 1'b0;
    i_v = 1'b1;
    for (int k = 0; k < 12; k++) begin
      din = 8'(8'h10 + k);
      tick();
    end
    settle_check();
    for (int g = 0; g < NI; g++) begin
      chk(cnt[g] == 8'(cap_of(g)), "full_cnt", g, cnt[g], cap_of(g));
      chk(ir[g] == 1'b0, "full_ir", g, ir[g], 0);
    end

    // Clock held: toggling o_r must not disturb any output of a registered-ready pipe.
    clk_run = 1'b0;
    for (int g = 0; g < NI; g++) begin
      snap_ir[g] = ir[g];
      snap_ov[g] = ov[g];
      snap_od[g] = od[g];
      snap_cn[g] = cnt[g];
    end
    for (int k = 0; k < 4; k++) begin
      o_r = ~o_r;
      #1;
      for (int g = 0; g < NI; g++) begin
        if (rr_of(g) == 1) begin
          chk(ir[g] == snap_ir[g], "hold_ir", g, ir[g], snap_ir[g]);
          chk(ov[g] == snap_ov[g], "hold_ov", g, ov[g], snap_ov[g]);
          chk(od[g] == snap_od[g], "hold_o", g, od[g], snap_od[g]);
          chk(cnt[g] == snap_cn[g], "hold_cnt", g, cnt[g], snap_cn[g]);
        end
      end
    end
    o_r = 1'b0;
    clk_run = 1'b1;
    advance();

    // Drain in order.
    o_r = 1'b1;
    i_v = 1'b0;
    for (int k = 0; k < 16; k++) tick();
    settle_check();
    for (int g = 0; g < NI; g++) begin
      chk(cnt[g] == 8'd0, "drain_cnt", g, cnt[g], 0);
      chk(ov[g] == 1'b0, "drain_ov", g, ov[g], 0);
    end
    advance();

    // Flush with four words held and a concurrent input.
    o_r = 1'b0;
    i_v = 1'b1;
    for (int k = 0; k < 4; k++) begin
      din = 8'(8'h40 + k);
      tick();
    end
    flush = 1'b1;
    din   = 8'hEE;
    settle_check();
    for (int g = 0; g < NI; g++) begin
      automatic int e = (cap_of(g) < 4) ? cap_of(g) : 4;
      chk(cnt[g] == 8'(e), "preflush_cnt", g, cnt[g], e);
    end
    advance();
    flush = 1'b0;
    i_v   = 1'b0;
    o_r   = 1'b1;
    settle_check();
    for (int g = 0; g < NI; g++) begin
      chk(ov[g] == 1'b0, "flush_ov", g, ov[g], 0);
      chk(cnt[g] == 8'd0, "flush_cnt", g, cnt[g], 0);
    end
    advance();
    for (int k = 0; k < 8; k++) tick();

    // Reset mid-stream, between edges.
    i_v = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din = 8'(8'h60 + k);
      tick();
    end
    #1;
    reset = 1'b1;
    #1;
    check_reset_state("reset_mid");
    model_reset();
    reset = 1'b0;
    din   = 8'hA5;
    i_v   = 1'b1;
    o_r   = 1'b1;
    tick();
    i_v = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      settle_check();
      for (int g = 0; g < NI; g++) begin
        chk(ov[g] == (t == dep_of(g)), "a5_ov", g, ov[g], int'(t == dep_of(g)));
        if (t == dep_of(g)) chk(od[g] == 8'hA5, "a5_o", g, od[g], 8'hA5);
      end
      advance();
    end

    // Random traffic with occasional flush.
    for (int c = 0; c < 10000; c++) begin
      i_v   = 1'($urandom_range(0, 1));
      o_r   = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 49) == 0);
      din   = 8'($urandom);
      tick();
    end
    flush = 1'b0;
    i_v   = 1'b0;
    o_r   = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    settle_check();
    for (int g = 0; g < NI; g++) begin
      chk(cnt[g] == 8'd0, "final_cnt", g, cnt[g], 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
